// File: rtl/seq_detector_param.sv
// seq_detector_param -- parameterised serial pattern detector.
//
// Accepts a serial bit stream (x qualified by x_valid and en). It compares
// the most recent PAT_W accepted bits against a loadable pattern and
// produces a registered one-cycle match pulse on z. Matches may overlap or
// not, as selected by the overlap input.
//
// Build option: define SEQ_DET_COUNT_EN to implement the saturating match
// counter on match_cnt. With it undefined, no counter registers exist and
// match_cnt is tied to zero.
//
// Reset: asynchronous, active-low on the port named `reset`.

module seq_detector_param #(
    parameter int unsigned      PAT_W   = 4,
    parameter int unsigned      CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b0110)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             en,
    input  logic             overlap,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    // Fill counter runs 0..PAT_W-1.
    localparam int unsigned        FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_W - 1);

    state_t              state_q;
    // Only the newest PAT_W-1 bits of the history window are ever compared:
    // the oldest bit of a PAT_W-bit window is shifted out before any
    // comparison could read it. The live window is {hist, x}.
    logic [PAT_W-2:0]    hist;
    logic [FILL_W-1:0]   fill;
    logic [FILL_W-1:0]   fill_inc;
    logic [PAT_W-1:0]    pattern;
    logic [PAT_W-1:0]    window;
    logic                accept;
    logic                match_hit;

    // A bit is accepted only when enabled, valid and not overridden by load.
    assign accept    = en & x_valid & ~load;
    assign window    = {hist, x};
    assign match_hit = accept && (state_q == ARMED) && (window == pattern);
    assign fill_inc  = (fill == FILL_MAX) ? fill : fill + 1'b1;
    assign state     = state_q;

    // Detector FSM: history shift, fill tracking, pattern load and match pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hist    <= '0;
            fill    <= '0;
            pattern <= RST_PAT;
            z       <= 1'b0;
        end else begin
            z <= match_hit;
            if (load) begin
                // Load wins over everything: new pattern, fresh window.
                pattern <= pat_in;
                hist    <= '0;
                fill    <= '0;
                state_q <= en ? FILL : IDLE;
            end else if (!en) begin
                hist    <= '0;
                fill    <= '0;
                state_q <= IDLE;
            end else if (x_valid) begin
                if (match_hit && !overlap) begin
                    // Non-overlapping: a match consumes the whole window.
                    hist    <= '0;
                    fill    <= '0;
                    state_q <= FILL;
                end else begin
                    hist    <= window[PAT_W-2:0];
                    fill    <= fill_inc;
                    state_q <= (fill_inc == FILL_MAX) ? ARMED : FILL;
                end
            end else if (state_q == IDLE) begin
                // Enabled with no data yet: start filling.
                state_q <= FILL;
            end
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of accepted matches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (match_hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param -- scoreboard bench for seq_detector_param.
// The driver updates a bit-queue reference model each cycle and pushes the
// expected post-edge outputs; a monitor pops one entry per clock and compares.

module tb_seq_detector_param;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             x;
    logic             x_valid;
    logic             en;
    logic             overlap;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic [1:0]       state;

    seq_detector_param #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .x_valid  (x_valid),
        .en       (en),
        .overlap  (overlap),
        .load     (load),
        .pat_in   (pat_in),
        .z        (z),
        .match_cnt(match_cnt),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             z;
        logic [1:0]       st;
        logic [CNT_W-1:0] cnt;
        int               step;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    // Reference model: the accepted bits since the last clear, at most PAT_W-1.
    logic [PAT_W-1:0] m_pat;
    bit               m_win[$];
    int               m_matches;
    logic             m_z;
    logic [1:0]       m_st;

    function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef SEQ_DET_COUNT_EN
        return (m_matches > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(m_matches);
`else
        return '0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int req, input int stp);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", name, stp, act, req);
        end
    endtask

    task automatic m_reset();
        m_pat     = 4'b0110;
        m_win.delete();
        m_matches = 0;
        m_z       = 1'b0;
        m_st      = 2'd0;
    endtask

    task automatic m_step(input logic ld, input logic [PAT_W-1:0] pin, input logic e,
                          input logic xv, input logic xb, input logic ov);
        logic [PAT_W-1:0] w;
        m_z = 1'b0;
        if (ld) begin
            m_pat = pin;
            m_win.delete();
            m_st = e ? 2'd1 : 2'd0;
        end else if (!e) begin
            m_win.delete();
            m_st = 2'd0;
        end else begin
            if (xv) begin
                if (m_win.size() == PAT_W - 1) begin
                    w = '0;
                    foreach (m_win[i]) w = {w[PAT_W-2:0], m_win[i]};
                    w = {w[PAT_W-2:0], xb};
                    if (w == m_pat) begin
                        m_z = 1'b1;
                        m_matches++;
                    end
                    if (m_z && !ov) begin
                        m_win.delete();
                    end else begin
                        m_win.push_back(xb);
                        void'(m_win.pop_front());
                    end
                end else begin
                    m_win.push_back(xb);
                end
            end
            m_st = (m_win.size() == PAT_W - 1) ? 2'd2 : 2'd1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.z    = m_z;
        e.st   = m_st;
        e.cnt  = exp_cnt();
        e.step = step_no;
        sb.push_back(e);
        step_no++;
    endtask

    task automatic drive(input logic ld, input logic [PAT_W-1:0] pin, input logic e,
                         input logic xv, input logic xb, input logic ov);
        @(negedge clk);
        reset   = 1'b1;
        load    = ld;
        pat_in  = pin;
        en      = e;
        x_valid = xv;
        x       = xb;
        overlap = ov;
        m_step(ld, pin, e, xv, xb, ov);
        push_exp();
    endtask

    // Hold reset low for n cycles; outputs must clear without waiting for a clock.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset   = 1'b0;
            load    = 1'b0;
            en      = 1'b0;
            x_valid = 1'b0;
            x       = 1'b0;
            m_reset();
            push_exp();
            if (i == 0) begin
                #1;
                check("async_rst_state", int'(state), 0, step_no);
                check("async_rst_z", int'(z), 0, step_no);
                check("async_rst_cnt", int'(match_cnt), 0, step_no);
            end
        end
    endtask

    // Send n bits of v, MSB first, all valid, with en high.
    task automatic send_bits(input logic [15:0] v, input int n, input logic ov);
        logic [15:0] t;
        t = v;
        for (int i = n - 1; i >= 0; i--) drive(1'b0, '0, 1'b1, 1'b1, t[i], ov);
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("z", int'(z), int'(e.z), e.step);
                check("state", int'(state), int'(e.st), e.step);
                check("match_cnt", int'(match_cnt), int'(e.cnt), e.step);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog step=%0d actual=timeout required=finish", step_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat_v;
        logic        ov_r;
        reset   = 1'b0;
        x       = 1'b0;
        x_valid = 1'b0;
        en      = 1'b0;
        overlap = 1'b1;
        load    = 1'b0;
        pat_in  = '0;
        m_reset();

        do_reset(2);

        // Default pattern 0110, overlapping: matches after bits 4 and 7.
        send_bits(16'b0110110, 7, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Same stream, non-overlapping: only one match.
        do_reset(1);
        send_bits(16'b0110110, 7, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Load 1011, bits separated by invalid cycles.
        do_reset(1);
        drive(1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b1);
        pat_v = 16'b1011;
        for (int i = 3; i >= 0; i--) begin
            drive(1'b0, '0, 1'b1, 1'b1, pat_v[i], 1'b1);
            drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        end

        // Pattern 1111 with x held high: counter saturates.
        do_reset(1);
        drive(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(16'hFF, 8, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset mid-pattern, then a lone 0 must not match.
        do_reset(1);
        send_bits(16'b011, 3, 1'b1);
        do_reset(1);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Drop en mid-pattern; a full 0110 is needed afterwards.
        do_reset(1);
        send_bits(16'b011, 3, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_bits(16'b0, 1, 1'b1);
        send_bits(16'b110, 3, 1'b1);

        // Load on a cycle that would otherwise match; load with en low.
        do_reset(1);
        send_bits(16'b011, 3, 1'b1);
        drive(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b1);
        send_bits(16'b1001001, 7, 1'b0);
        send_bits(16'b001, 3, 1'b1);

        // Randomised traffic.
        ov_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1);
            end else begin
                if ($urandom_range(0, 7) == 0) ov_r = ~ov_r;
                drive(($urandom_range(0, 39) == 0), PAT_W'($urandom),
                      ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                      1'($urandom), ov_r);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drain", sb.size(), 0, step_no);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width (legal 1..16).
REQ-003 SHALL have parameter RST_PAT, default 4'b0110 zero-extended to PAT_W, pattern value after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-006 x  input  1  serial data bit.
REQ-007 x_valid  input  1  x is sampled only on cycles where x_valid=1.
REQ-008 en  input  1  detector enable; 0 = idle, no sampling.
REQ-009 overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-010 load  input  1  one-cycle strobe capturing pat_in as the new pattern.
REQ-011 pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit expected on x.
REQ-012 z  output  1  registered match pulse.
REQ-013 match_cnt  output  CNT_W  saturating count of matches.
REQ-014 state  output  2  current FSM state (IDLE=0, FILL=1, ARMED=2).

Function
REQ-015 SHALL keep a PAT_W-bit history register hist (newest bit in bit 0) and a fill counter 0..PAT_W-1.
REQ-016 FSM: IDLE -> FILL when en=1; FILL -> ARMED when the accepted bit brings fill to PAT_W-1; any state -> IDLE when en=0, and hist/fill clear on that transition.
REQ-017 An accepted bit (en=1, x_valid=1) SHALL shift hist left by one with x in bit 0 and increment fill (saturating at PAT_W-1).
REQ-018 A match SHALL be {hist[PAT_W-2:0], x} == pattern, evaluated only on an accepted bit in ARMED.
REQ-019 z SHALL be 1 for exactly the one cycle after the edge on which a match is accepted, otherwise 0.
REQ-020 overlap=1: after a match, the FSM stays in ARMED; overlap=0: after a match, hist and fill clear and the FSM returns to FILL.
REQ-021 x_valid=0 cycles SHALL hold hist, fill and state unchanged and produce z=0.
REQ-022 load=1 SHALL capture pat_in, clear hist and fill, force state FILL (IDLE if en=0), suppress any match on that cycle, and take priority over sampling.
REQ-023 match_cnt SHALL increment by 1 on each match and hold at 2^CNT_W-1 (no wrap).
REQ-024 The overlap input is sampled per cycle; changing it mid-stream affects only the next match decision.

Reset
REQ-025 With reset low: state=IDLE, hist=0, fill=0, z=0, match_cnt=0, pattern=RST_PAT.
REQ-026 Reset deassertion SHALL take effect on the next rising clk edge; no match on that edge.

Configuration
REQ-027 SEQ_DET_COUNT_EN defined: match_cnt is implemented per REQ-023.
REQ-028 SEQ_DET_COUNT_EN undefined: no counter registers exist and match_cnt is tied to 0; all other behaviour is unchanged.

Verification
REQ-029 Default pattern 0110, overlap=1, x=0,1,1,0,1,1,0 all valid -> z pulses after bit 4 and after bit 7; match_cnt=2.
REQ-030 Same stream with overlap=0 -> z pulses only after bit 4; match_cnt=1.
REQ-031 load pat_in=4'b1011, then x=1,0,1,1 with x_valid low between bits -> a single z after the 4th accepted bit; idle cycles produce z=0.
REQ-032 CNT_W=2, 5 consecutive matches (overlap=1, pattern 1111, x held at 1 for 8 bits) -> match_cnt saturates at 3.
REQ-033 Reset low after bits 0,1,1 of 0110, then release and send 0 -> no z; state=FILL after en; match_cnt=0.
REQ-034 en dropped after 0,1,1, raised again, then 0 -> no z; a full 0110 is then needed for a match.
